// File: rtl/fft_bfly_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bfly_sequencer
//  Description : Issue-side controller for the radix-2 DIF FFT datapath.
//                Walks every butterfly of every stage, drives operand and
//                twiddle addresses, pulses one iteration strobe per completed
//                butterfly and waits for the end-of-stage strobe between
//                stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_bfly_sequencer #(
    parameter int LOG2N = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     bfly_done,
    input  logic                     stage_strobe,
    output logic                     bfly_go,
    output logic [LOG2N-1:0]         top_addr,
    output logic [LOG2N-1:0]         bot_addr,
    output logic [LOG2N-2:0]         twiddle_addr,
    output logic                     iteration_strobe,
    output logic [$clog2(LOG2N)-1:0] stage_count_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    // Stage index width; LOG2N must be at least 2.
    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;

    localparam logic [SW-1:0]    c_S_LAST = SW'(LOG2N - 1);
    localparam logic [KW-1:0]    c_K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0]    c_S_ONE  = SW'(1);
    localparam logic [KW-1:0]    c_K_ONE  = KW'(1);
    localparam logic [LOG2N-1:0] c_A_ONE  = LOG2N'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT       = 3'd2,
        S_STAGE_WAIT = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SW-1:0]    r_s;
    logic [KW-1:0]    r_k;
    logic             r_err;
    logic             r_iter_strobe;

    logic [SW-1:0]    w_sh;
    logic [KW-1:0]    w_mask;
    logic [KW-1:0]    w_pos;
    logic [KW-1:0]    w_grp;
    logic [LOG2N-1:0] w_span;
    logic [LOG2N-1:0] w_top;
    logic [LOG2N-1:0] w_bot;
    logic [KW-1:0]    w_tw;
    logic             w_idle;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bfly_done) begin
                    w_state_nxt = (r_k == c_K_LAST) ? S_STAGE_WAIT : S_ISSUE;
                end
            end
            S_STAGE_WAIT: begin
                if (stage_strobe) begin
                    w_state_nxt = (r_s == c_S_LAST) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage/butterfly counters, sticky error and the completion strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s           <= '0;
            r_k           <= '0;
            r_err         <= 1'b0;
            r_iter_strobe <= 1'b0;
        end else begin
            r_iter_strobe <= (r_state == S_WAIT) && bfly_done;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_s <= '0;
                        r_k <= '0;
                    end
                end
                S_WAIT: begin
                    if (bfly_done) begin
                        r_k <= (r_k == c_K_LAST) ? '0 : r_k + c_K_ONE;
                    end
                end
                S_STAGE_WAIT: begin
                    if (stage_strobe && (r_s != c_S_LAST)) begin
                        r_s <= r_s + c_S_ONE;
                    end
                end
                S_DONE: begin
                    r_s <= '0;
                    r_k <= '0;
                end
                default: begin
                end
            endcase
            // An accepted start wins over a simultaneous stray stage strobe.
            if ((r_state == S_IDLE) && start) begin
                r_err <= 1'b0;
            end else if (stage_strobe && (r_state != S_STAGE_WAIT)) begin
                r_err <= 1'b1;
            end
        end
    end

    // DIF addressing: span halves each stage; k splits into group and
    // position inside the group at bit (LOG2N-1-s).
    assign w_sh   = c_S_LAST - r_s;
    assign w_mask = ~({KW{1'b1}} << w_sh);
    assign w_pos  = r_k & w_mask;
    assign w_grp  = r_k >> w_sh;
    assign w_span = c_A_ONE << w_sh;
    assign w_top  = (({1'b0, w_grp} << w_sh) << 1) | {1'b0, w_pos};
    assign w_bot  = w_top + w_span;
    assign w_tw   = w_pos << r_s;
    assign w_idle = (r_state == S_IDLE);

    // Addresses are forced to zero while idle so bot_addr does not show N/2.
    assign top_addr         = w_idle ? '0 : w_top;
    assign bot_addr         = w_idle ? '0 : w_bot;
    assign twiddle_addr     = w_idle ? '0 : w_tw;
    assign stage_count_out  = r_s;
    assign bfly_go          = (r_state == S_ISSUE);
    assign busy             = !w_idle;
    assign done             = (r_state == S_DONE);
    assign err              = r_err;
    assign iteration_strobe = r_iter_strobe;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_bfly_sequencer
//  Description : Self-checking bench for fft_bfly_sequencer with an address
//                scoreboard and a behavioural no_iter counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bfly_sequencer;

    localparam int LOG2N = 5;
    localparam int N     = 1 << LOG2N;
    localparam int HALF  = N / 2;

    logic             tb_clk = 1'b0;
    logic             reset;
    logic             start;
    logic             bfly_done;
    logic             tb_stage_strobe;
    logic             stage_strobe;
    logic             bfly_go;
    logic [LOG2N-1:0] top_addr;
    logic [LOG2N-1:0] bot_addr;
    logic [LOG2N-2:0] twiddle_addr;
    logic             iteration_strobe;
    logic [2:0]       stage_count_out;
    logic             busy;
    logic             done;
    logic             err;

    logic             use_ni;
    logic [3:0]       ni_count;
    logic             ni_stage_strobe;

    int tests       = 0;
    int fails       = 0;
    int cyc         = 0;
    int istrobe_cnt = 0;
    int done_cnt    = 0;

    typedef struct {
        int s;
        int top;
        int bot;
        int tw;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 tb_clk = ~tb_clk;

    // Free-running edge counter used for latency measurement.
    always @(posedge tb_clk) cyc <= cyc + 1;

    assign stage_strobe = tb_stage_strobe | (use_ni & ni_stage_strobe);

    fft_bfly_sequencer #(.LOG2N(LOG2N)) dut (
        .clk              (tb_clk),
        .reset            (reset),
        .start            (start),
        .bfly_done        (bfly_done),
        .stage_strobe     (stage_strobe),
        .bfly_go          (bfly_go),
        .top_addr         (top_addr),
        .bot_addr         (bot_addr),
        .twiddle_addr     (twiddle_addr),
        .iteration_strobe (iteration_strobe),
        .stage_count_out  (stage_count_out),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    // Behavioural no_iter: wraps every HALF strobes and then pulses stage_strobe.
    always @(posedge tb_clk or posedge reset) begin
        if (reset) begin
            ni_count        <= '0;
            ni_stage_strobe <= 1'b0;
        end else begin
            ni_stage_strobe <= 1'b0;
            if (iteration_strobe) begin
                if (ni_count == 4'(HALF - 1)) begin
                    ni_count        <= '0;
                    ni_stage_strobe <= 1'b1;
                end else begin
                    ni_count <= ni_count + 4'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: count strobes and compare each issued butterfly to the scoreboard.
    always @(negedge tb_clk) begin
        if (iteration_strobe === 1'b1) istrobe_cnt++;
        if (done === 1'b1) done_cnt++;
        if (bfly_go === 1'b1) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sb_top", top_addr, mon_e.top);
                check("sb_bot", bot_addr, mon_e.bot);
                check("sb_tw", twiddle_addr, mon_e.tw);
                check("sb_stage", stage_count_out, mon_e.s);
            end
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // Reference DIF order: per stage, groups of 2*span, positions within group.
    task automatic push_expected();
        exp_t e;
        for (int s = 0; s < LOG2N; s++) begin
            int span;
            span = HALF >> s;
            for (int g = 0; g < HALF / span; g++) begin
                for (int j = 0; j < span; j++) begin
                    e.s   = s;
                    e.top = g * 2 * span + j;
                    e.bot = e.top + span;
                    e.tw  = (j << s) % HALF;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_go(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bfly_go === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("go_timeout", 32'(ok), 1);
    endtask

    task automatic spec_addr(input int s, input int b);
        if (s == 0 && b == 0) begin
            check("s0k0_top", top_addr, 0);  check("s0k0_bot", bot_addr, 16); check("s0k0_tw", twiddle_addr, 0);
        end
        if (s == 1 && b == 8) begin
            check("s1k8_top", top_addr, 16); check("s1k8_bot", bot_addr, 24); check("s1k8_tw", twiddle_addr, 0);
        end
        if (s == 2 && b == 5) begin
            check("s2k5_top", top_addr, 9);  check("s2k5_bot", bot_addr, 13); check("s2k5_tw", twiddle_addr, 4);
        end
        if (s == 4 && b == 3) begin
            check("s4k3_top", top_addr, 6);  check("s4k3_bot", bot_addr, 7);  check("s4k3_tw", twiddle_addr, 0);
        end
    endtask

    // One transform. noiter: stage strobes come from the no_iter model.
    // inject_err: stray stage strobe in WAIT. noise: start/bfly_done in ISSUE.
    // abort_stage: assert reset in the first WAIT of that stage (-1 = never).
    task automatic run_xform(input bit noiter, input bit inject_err, input bit noise, input int abort_stage);
        int t0;
        int base;
        int dbase;
        int hold_top;
        int hold_bot;
        bit ok;
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_go", bfly_go, 1);
        check("start_err_clr", err, 0);
        t0    = cyc;
        base  = istrobe_cnt;
        dbase = done_cnt;
        for (int s = 0; s < LOG2N; s++) begin
            for (int b = 0; b < HALF; b++) begin
                wait_go(ok);
                if (!ok) return;
                if (b == 0) begin
                    check("stage_idx", stage_count_out, s);
                    check("stage_strobes", istrobe_cnt - base, 16 * s);
                    if (noiter && s > 0) check("ni_wrap", ni_count, 0);
                end
                spec_addr(s, b);
                hold_top = top_addr;
                hold_bot = bot_addr;
                if (noise && s == 1) begin
                    start     = 1'b1;
                    bfly_done = 1'b1;
                end
                tick();
                start     = 1'b0;
                bfly_done = 1'b0;
                if (abort_stage == s) begin
                    reset = 1'b1;
                    #2;
                    check("rst_go", bfly_go, 0);
                    check("rst_busy", busy, 0);
                    check("rst_top", top_addr, 0);
                    check("rst_bot", bot_addr, 0);
                    check("rst_tw", twiddle_addr, 0);
                    check("rst_stage", stage_count_out, 0);
                    check("rst_strobe", iteration_strobe, 0);
                    check("rst_done", done, 0);
                    sb.delete();
                    tick();
                    reset = 1'b0;
                    tick();
                    check("rst_no_done", done_cnt - dbase, 0);
                    return;
                end
                if (noise && s == 1) begin
                    tick();
                    check("noise_go", bfly_go, 0);
                    check("noise_strobe", iteration_strobe, 0);
                end
                if (inject_err && s == 0 && b == 2) begin
                    tb_stage_strobe = 1'b1;
                    tick();
                    tb_stage_strobe = 1'b0;
                    check("err_set", err, 1);
                    check("err_go", bfly_go, 0);
                end
                check("hold_top", top_addr, hold_top);
                check("hold_bot", bot_addr, hold_bot);
                bfly_done = 1'b1;
                tick();
                bfly_done = 1'b0;
                check("iter_strobe", iteration_strobe, 1);
                if (b != HALF - 1) check("b2b_go", bfly_go, 1);
            end
            if (!noiter) begin
                tick();
                tick();
                tb_stage_strobe = 1'b1;
                tick();
                tb_stage_strobe = 1'b0;
            end
        end
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        check("done_seen", done, 1);
        check("done_busy", busy, 1);
        check("total_strobes", istrobe_cnt - base, LOG2N * 16);
        check("err_final", err, 32'(inject_err));
        if (noiter) check("ni_final", ni_count, 0);
        if (!noiter && !inject_err && !noise) check("latency", cyc - t0, 175);
        tick();
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("idle_top", top_addr, 0);
        check("idle_bot", bot_addr, 0);
        check("done_count", done_cnt - dbase, 1);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        bfly_done       = 1'b0;
        tb_stage_strobe = 1'b0;
        use_ni          = 1'b0;
        tick();
        tick();
        check("reset_go", bfly_go, 0);
        check("reset_busy", busy, 0);
        check("reset_top", top_addr, 0);
        check("reset_bot", bot_addr, 0);
        check("reset_tw", twiddle_addr, 0);
        check("reset_stage", stage_count_out, 0);
        check("reset_strobe", iteration_strobe, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        reset = 1'b0;
        tick();
        check("idle_bot0", bot_addr, 0);

        // bfly_done while idle is ignored.
        bfly_done = 1'b1;
        tick();
        tick();
        bfly_done = 1'b0;
        check("idle_bd_busy", busy, 0);
        check("idle_bd_strobe", iteration_strobe, 0);
        tick();
        check("idle_bd_strobe2", iteration_strobe, 0);

        // Stray stage strobe while idle sets err; next start clears it.
        tb_stage_strobe = 1'b1;
        tick();
        tb_stage_strobe = 1'b0;
        check("idle_ss_err", err, 1);
        check("idle_ss_busy", busy, 0);

        run_xform(1'b0, 1'b0, 1'b0, -1);
        run_xform(1'b0, 1'b1, 1'b1, -1);
        run_xform(1'b0, 1'b0, 1'b0, 2);
        run_xform(1'b0, 1'b0, 1'b0, -1);
        use_ni = 1'b1;
        run_xform(1'b1, 1'b0, 1'b0, -1);
        use_ni = 1'b0;
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
